// File: rtl/ddr3_init_engine.sv
// DDR3 power-up / re-initialisation sequencer: RESET#, CKE, MR2/MR3/MR1/MR0 MRS, ZQCL, then ready.
// Every output is a flop fed from the current state and counter, so outputs trail the state by one edge.
module ddr3_init_engine #(
   parameter int          T_RESET  = 20,
   parameter int          T_CKE    = 50,
   parameter int          T_XPR    = 10,
   parameter int          T_MRD    = 4,
   parameter int          T_MOD    = 12,
   parameter int          T_ZQINIT = 64,
   parameter logic [12:0] MR0_VAL  = 13'h0160,
   parameter logic [12:0] MR1_VAL  = 13'h0000,
   parameter logic [12:0] MR2_VAL  = 13'h0000,
   parameter logic [12:0] MR3_VAL  = 13'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        reinit,
   output logic        ready,
   output logic        rst_bar,
   output logic        cke,
   output logic        odt,
   output logic        cs_bar,
   output logic        ras_bar,
   output logic        cas_bar,
   output logic        we_bar,
   output logic [2:0]  BA,
   output logic [12:0] A,
   output logic [3:0]  init_state
);

   localparam int CW = 16;

   typedef enum logic [3:0] {
      RST_LOW  = 4'd0,
      CKE_WAIT = 4'd1,
      XPR      = 4'd2,
      MRS2     = 4'd3,
      MRS3     = 4'd4,
      MRS1     = 4'd5,
      MRS0     = 4'd6,
      ZQCL     = 4'd7,
      DONE     = 4'd8
   } state_t;

   localparam logic [3:0] CMD_DESEL = 4'b1111;
   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_MRS   = 4'b0000;
   localparam logic [3:0] CMD_ZQCL  = 4'b0110;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   dur_m1;
   state_t          nxt;

   logic            ready_q, ready_d;
   logic            rst_bar_q, rst_bar_d;
   logic            cke_q, cke_d;
   logic            odt_q, odt_d;
   logic [3:0]      cmd_q, cmd_d;
   logic [2:0]      ba_q, ba_d;
   logic [12:0]     a_q, a_d;
   logic [3:0]      init_state_q, init_state_d;

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      dur_m1  = '0;
      nxt     = DONE;
      case (state_q)
         RST_LOW:  begin dur_m1 = CW'(T_RESET - 1);  nxt = CKE_WAIT; end
         CKE_WAIT: begin dur_m1 = CW'(T_CKE - 1);    nxt = XPR;      end
         XPR:      begin dur_m1 = CW'(T_XPR - 1);    nxt = MRS2;     end
         MRS2:     begin dur_m1 = CW'(T_MRD - 1);    nxt = MRS3;     end
         MRS3:     begin dur_m1 = CW'(T_MRD - 1);    nxt = MRS1;     end
         MRS1:     begin dur_m1 = CW'(T_MRD - 1);    nxt = MRS0;     end
         MRS0:     begin dur_m1 = CW'(T_MOD - 1);    nxt = ZQCL;     end
         ZQCL:     begin dur_m1 = CW'(T_ZQINIT - 1); nxt = DONE;     end
         default:  begin dur_m1 = '0;                nxt = DONE;     end
      endcase

      if (state_q == DONE) begin
         // Counter is parked in DONE; reinit is only looked at here.
         cnt_d = '0;
         if (reinit) state_d = RST_LOW;
      end else if (cnt_q == dur_m1) begin
         cnt_d   = '0;
         state_d = nxt;
      end
   end

   always_comb begin
      rst_bar_d    = (state_q != RST_LOW);
      cke_d        = (state_q != RST_LOW) && (state_q != CKE_WAIT);
      odt_d        = 1'b0;
      cmd_d        = cke_d ? CMD_NOP : CMD_DESEL;
      ba_d         = '0;
      a_d          = '0;
      ready_d      = (state_q == DONE);
      init_state_d = state_q;

      // Commands go out only on the first cycle of their state; the rest of the state is NOP.
      if (cnt_q == '0) begin
         case (state_q)
            MRS2:    begin cmd_d = CMD_MRS;  ba_d = 3'd2; a_d = MR2_VAL;  end
            MRS3:    begin cmd_d = CMD_MRS;  ba_d = 3'd3; a_d = MR3_VAL;  end
            MRS1:    begin cmd_d = CMD_MRS;  ba_d = 3'd1; a_d = MR1_VAL;  end
            MRS0:    begin cmd_d = CMD_MRS;  ba_d = 3'd0; a_d = MR0_VAL;  end
            ZQCL:    begin cmd_d = CMD_ZQCL; ba_d = 3'd0; a_d = 13'h0400; end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= RST_LOW;
         cnt_q        <= '0;
         ready_q      <= 1'b0;
         rst_bar_q    <= 1'b0;
         cke_q        <= 1'b0;
         odt_q        <= 1'b0;
         cmd_q        <= CMD_DESEL;
         ba_q         <= '0;
         a_q          <= '0;
         init_state_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ready_q      <= ready_d;
         rst_bar_q    <= rst_bar_d;
         cke_q        <= cke_d;
         odt_q        <= odt_d;
         cmd_q        <= cmd_d;
         ba_q         <= ba_d;
         a_q          <= a_d;
         init_state_q <= init_state_d;
      end
   end

   assign ready      = ready_q;
   assign rst_bar    = rst_bar_q;
   assign cke        = cke_q;
   assign odt        = odt_q;
   assign cs_bar     = cmd_q[3];
   assign ras_bar    = cmd_q[2];
   assign cas_bar    = cmd_q[1];
   assign we_bar     = cmd_q[0];
   assign BA         = ba_q;
   assign A          = a_q;
   assign init_state = init_state_q;

endmodule

// File: tb/tb_ddr3_init_engine.sv
// Scoreboard bench for ddr3_init_engine: a timeline model predicts every output per edge,
// a negedge monitor pops and compares.
module tb_ddr3_init_engine;

   localparam int          T_RESET  = 20;
   localparam int          T_CKE    = 50;
   localparam int          T_XPR    = 10;
   localparam int          T_MRD    = 4;
   localparam int          T_MOD    = 12;
   localparam int          T_ZQINIT = 64;
   localparam logic [12:0] MR0_VAL  = 13'h0160;
   localparam logic [12:0] MR1_VAL  = 13'h0000;
   localparam logic [12:0] MR2_VAL  = 13'h0000;
   localparam logic [12:0] MR3_VAL  = 13'h0000;

   // Edge (counted from release) at which each phase first shows on the outputs.
   localparam int B1 = T_RESET;
   localparam int B2 = B1 + T_CKE;
   localparam int B3 = B2 + T_XPR;
   localparam int B4 = B3 + T_MRD;
   localparam int B5 = B4 + T_MRD;
   localparam int B6 = B5 + T_MRD;
   localparam int B7 = B6 + T_MOD;
   localparam int B8 = B7 + T_ZQINIT;

   typedef struct packed {
      logic        ready;
      logic        rst_bar;
      logic        cke;
      logic        odt;
      logic [3:0]  cmd;
      logic [2:0]  ba;
      logic [12:0] a;
      logic [3:0]  st;
   } obs_t;

   typedef struct {
      int   edge_n;
      obs_t exp;
   } sb_t;

   logic        clk;
   logic        reset;
   logic        reinit;
   logic        ready, rst_bar, cke, odt, cs_bar, ras_bar, cas_bar, we_bar;
   logic [2:0]  BA;
   logic [12:0] A;
   logic [3:0]  init_state;

   int   total;
   int   bad;
   int   t_model;
   int   edge_cnt;
   bit   drv_done;
   sb_t  sb[$];

   ddr3_init_engine #(
      .T_RESET(T_RESET), .T_CKE(T_CKE), .T_XPR(T_XPR), .T_MRD(T_MRD),
      .T_MOD(T_MOD), .T_ZQINIT(T_ZQINIT),
      .MR0_VAL(MR0_VAL), .MR1_VAL(MR1_VAL), .MR2_VAL(MR2_VAL), .MR3_VAL(MR3_VAL)
   ) dut (
      .clk(clk), .reset(reset), .reinit(reinit), .ready(ready),
      .rst_bar(rst_bar), .cke(cke), .odt(odt),
      .cs_bar(cs_bar), .ras_bar(ras_bar), .cas_bar(cas_bar), .we_bar(we_bar),
      .BA(BA), .A(A), .init_state(init_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic obs_t reset_obs();
      obs_t o;
      o = '0;
      o.cmd = 4'b1111;
      return o;
   endfunction

   // Expected outputs t edges after the sequence (re)started.
   function automatic obs_t expect_at(input int t);
      obs_t o;
      int   bnd [9];
      bnd = '{0, B1, B2, B3, B4, B5, B6, B7, B8};
      o         = '0;
      o.rst_bar = (t >= B1);
      o.cke     = (t >= B2);
      o.ready   = (t >= B8);
      o.cmd     = o.cke ? 4'b0111 : 4'b1111;
      for (int k = 0; k < 9; k++)
         if (t >= bnd[k]) o.st = 4'(k);
      if (t == B3) begin o.cmd = 4'b0000; o.ba = 3'd2; o.a = MR2_VAL;  end
      if (t == B4) begin o.cmd = 4'b0000; o.ba = 3'd3; o.a = MR3_VAL;  end
      if (t == B5) begin o.cmd = 4'b0000; o.ba = 3'd1; o.a = MR1_VAL;  end
      if (t == B6) begin o.cmd = 4'b0000; o.ba = 3'd0; o.a = MR0_VAL;  end
      if (t == B7) begin o.cmd = 4'b0110; o.ba = 3'd0; o.a = 13'h0400; end
      return o;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // One clock: present inputs, predict the outputs after the coming edge, queue the prediction.
   task automatic cyc(input logic r, input logic ri);
      obs_t pend;
      sb_t  item;
      reset  = r;
      reinit = ri;
      if (r) begin
         pend    = reset_obs();
         t_model = 0;
      end else begin
         pend = expect_at(t_model);
         if (ri && t_model >= B8) t_model = 0;
         else if (t_model < B8)   t_model++;
      end
      @(posedge clk);
      #2;
      item.edge_n = edge_cnt;
      item.exp    = pend;
      sb.push_back(item);
      edge_cnt++;
   endtask

   initial begin : monitor
      sb_t  e;
      obs_t act;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {ready, rst_bar, cke, odt, cs_bar, ras_bar, cas_bar, we_bar, BA, A, init_state};
            check($sformatf("outs@edge%0d", e.edge_n), 32'(act), 32'(e.exp));
         end
      end
   end

   initial begin : driver
      total    = 0;
      bad      = 0;
      t_model  = 0;
      edge_cnt = 0;
      drv_done = 1'b0;

      // Plain bring-up, reinit before DONE (ignored) and in DONE (restart).
      repeat (3) cyc(1'b1, 1'b0);
      for (int e = 0; e <= 400; e++) cyc(1'b0, (e == 100) || (e == 200));

      // Reset pulse in the middle of MRS1.
      cyc(1'b1, 1'b0);
      for (int e = 0; e <= 90; e++) cyc(e == 90, 1'b0);
      for (int e = 0; e <= 200; e++) cyc(1'b0, 1'b0);

      // reset and reinit together in DONE: reset wins.
      cyc(1'b1, 1'b1);
      for (int e = 0; e <= 180; e++) cyc(1'b0, 1'b0);

      // Random reset pulses and reinit requests.
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 399) == 0, $urandom_range(0, 29) == 0);

      cyc(1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      drv_done = 1'b1;
      $finish;
   end

endmodule
